// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side and MMU-side signal bundle for
// mem_port_arbiter. Requester vectors are indexed [1:0] (0 = Ibex data,
// 1 = Vicuna vector memory).
interface mem_port_arbiter_if #(
  parameter int unsigned MEM_W = 32
);
  localparam int unsigned BE_W = MEM_W / 8;

  // requester side
  logic [1:0]                  req;
  logic [1:0][31:0]            addr;
  logic [1:0]                  we;
  logic [1:0][BE_W-1:0]        be;
  logic [1:0][MEM_W-1:0]       wdata;
  logic [1:0]                  gnt;
  logic [1:0]                  rvalid;
  logic                        err;
  logic [MEM_W-1:0]            rdata;

  // MMU side
  logic                        mem_req;
  logic [31:0]                 mem_addr;
  logic                        mem_we;
  logic [BE_W-1:0]             mem_be;
  logic [MEM_W-1:0]            mem_wdata;
  logic                        mem_gnt;
  logic                        mem_rvalid;
  logic                        mem_err;
  logic [MEM_W-1:0]            mem_rdata;

  // arbiter view
  modport slave (
    input  req, addr, we, be, wdata,
    input  mem_gnt, mem_rvalid, mem_err, mem_rdata,
    output gnt, rvalid, err, rdata,
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata
  );

  // requesters + MMU view
  modport master (
    output req, addr, we, be, wdata,
    output mem_gnt, mem_rvalid, mem_err, mem_rdata,
    input  gnt, rvalid, err, rdata,
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single MMU memory port between two requesters.
// One transaction outstanding, round-robin on ties, responses routed to the
// owner. Optional response watchdog enabled by MEM_PORT_ARB_WATCHDOG_EN.
module mem_port_arbiter #(
  parameter int unsigned MEM_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,   // asynchronous, active-low
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned BE_W = MEM_W / 8;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_owner;
  logic              r_last;
  logic              r_mem_req;
  logic [31:0]       r_mem_addr;
  logic              r_mem_we;
  logic [BE_W-1:0]   r_mem_be;
  logic [MEM_W-1:0]  r_mem_wdata;

  logic              w_any_req;
  logic              w_winner;
  logic              w_timeout;
  logic [1:0]        w_gnt;
  logic [1:0]        w_rvalid;
  logic              w_err;
  logic [MEM_W-1:0]  w_rdata;

`ifdef MEM_PORT_ARB_WATCHDOG_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wd_cnt;

  // Watchdog counter: cleared on entry to RESP, counts silent RESP cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt <= '0;
    end else if (r_state == REQ && bus.mem_gnt) begin
      r_wd_cnt <= '0;
    end else if (r_state == RESP && !bus.mem_rvalid) begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_state == RESP) && !bus.mem_rvalid && (r_wd_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // Winner selection: single requester wins outright, ties go to ~last.
  always_comb begin
    w_any_req = |bus.req;
    w_winner  = 1'b0;
    unique case (bus.req)
      2'b01:   w_winner = 1'b0;
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = ~r_last;
      default: w_winner = 1'b0;
    endcase
  end

  // Control FSM with registered downstream request and payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner     <= w_winner;
            r_last      <= w_winner;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= bus.addr[w_winner];
            r_mem_we    <= bus.we[w_winner];
            r_mem_be    <= bus.be[w_winner];
            r_mem_wdata <= bus.wdata[w_winner];
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= RESP;
          end
        end
        RESP: begin
          if (bus.mem_rvalid || w_timeout) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Grant/response steering to the owner; rdata/err zero without rvalid.
  always_comb begin
    w_gnt    = '0;
    w_rvalid = '0;
    w_err    = 1'b0;
    w_rdata  = '0;
    if (r_state == REQ) begin
      w_gnt[r_owner] = bus.mem_gnt;
    end
    if (r_state == RESP) begin
      if (bus.mem_rvalid) begin
        w_rvalid[r_owner] = 1'b1;
        w_err             = bus.mem_err;
        w_rdata           = bus.mem_rdata;
      end else if (w_timeout) begin
        w_rvalid[r_owner] = 1'b1;
        w_err             = 1'b1;
      end
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.rvalid    = w_rvalid;
  assign bus.err       = w_err;
  assign bus.rdata     = w_rdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a grant/response scoreboard.
// Expected grants and responses are queued as each transaction is issued;
// a negedge monitor pops and compares whenever the DUT shows gnt or rvalid.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;

  mem_port_arbiter_if #(.MEM_W(32)) bif ();

  mem_port_arbiter #(
    .MEM_W          (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  gvec;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct {
    logic [1:0]  rvec;
    logic        err;
    logic [31:0] rdata;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  gexp_t mg;
  rexp_t mr;
  always @(negedge clk) begin
    if (rst) begin
      if (bif.gnt != 2'b00) begin
        if (gq.size() == 0) begin
          check("unexpected_gnt", {30'd0, bif.gnt}, 32'd0);
        end else begin
          mg = gq.pop_front();
          check("gnt_vec",   {30'd0, bif.gnt}, {30'd0, mg.gvec});
          check("gnt_mreq",  {31'd0, bif.mem_req}, 32'd1);
          check("gnt_addr",  bif.mem_addr, mg.addr);
          check("gnt_we",    {31'd0, bif.mem_we}, {31'd0, mg.we});
          check("gnt_be",    {28'd0, bif.mem_be}, {28'd0, mg.be});
          check("gnt_wdata", bif.mem_wdata, mg.wdata);
        end
      end
      if (bif.rvalid != 2'b00) begin
        if (rq.size() == 0) begin
          check("unexpected_rvalid", {30'd0, bif.rvalid}, 32'd0);
        end else begin
          mr = rq.pop_front();
          check("rvalid_vec", {30'd0, bif.rvalid}, {30'd0, mr.rvec});
          check("rsp_err",    {31'd0, bif.err}, {31'd0, mr.err});
          check("rsp_rdata",  bif.rdata, mr.rdata);
        end
      end else begin
        check("idle_err_zero",   {31'd0, bif.err}, 32'd0);
        check("idle_rdata_zero", bif.rdata, 32'd0);
      end
    end
  end

  task automatic reset_dut();
    rst = 1'b0;
    bif.req        = '0;
    bif.mem_gnt    = 1'b0;
    bif.mem_rvalid = 1'b0;
    bif.mem_err    = 1'b0;
    bif.mem_rdata  = 32'hA5A5_A5A5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt",       {30'd0, bif.gnt}, 32'd0);
    check("rst_rvalid",    {30'd0, bif.rvalid}, 32'd0);
    check("rst_err",       {31'd0, bif.err}, 32'd0);
    check("rst_rdata",     bif.rdata, 32'd0);
    check("rst_mem_req",   {31'd0, bif.mem_req}, 32'd0);
    check("rst_mem_addr",  bif.mem_addr, 32'd0);
    check("rst_mem_we",    {31'd0, bif.mem_we}, 32'd0);
    check("rst_mem_be",    {28'd0, bif.mem_be}, 32'd0);
    check("rst_mem_wdata", bif.mem_wdata, 32'd0);
    tick();
    rst = 1'b1;
  endtask

  // Full transaction for requester r; starts with the DUT in IDLE and ends
  // one timestep into the following IDLE cycle.
  task automatic run_txn(input bit r, input logic [31:0] a, input bit w,
                         input logic [3:0] b, input logic [31:0] wd,
                         input int gdly, input int rdly, input bit e,
                         input logic [31:0] rd, input bit rearm);
    gexp_t g;
    rexp_t x;
    logic [1:0] vec;
    vec = r ? 2'b10 : 2'b01;
    g.gvec = vec; g.addr = a; g.we = w; g.be = b; g.wdata = wd;
    x.rvec = vec; x.err = e; x.rdata = rd;
    gq.push_back(g);
    rq.push_back(x);
    bif.req[r]   = 1'b1;
    bif.addr[r]  = a;
    bif.we[r]    = w;
    bif.be[r]    = b;
    bif.wdata[r] = wd;
    bif.mem_gnt  = 1'b0;
    tick();
    for (int i = 0; i < gdly; i++) begin
      @(negedge clk);
      check("stall_mem_req", {31'd0, bif.mem_req}, 32'd1);
      check("stall_addr",    bif.mem_addr, a);
      check("stall_be",      {28'd0, bif.mem_be}, {28'd0, b});
      check("stall_wdata",   bif.mem_wdata, wd);
      check("stall_no_gnt",  {30'd0, bif.gnt}, 32'd0);
      tick();
    end
    bif.mem_gnt = 1'b1;
    @(negedge clk);
    check("gnt_timing", {31'd0, bif.gnt[r]}, 32'd1);
    tick();
    bif.req[r]  = 1'b0;
    bif.mem_gnt = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      check("resp_wait_mem_req", {31'd0, bif.mem_req}, 32'd0);
      check("resp_wait_rvalid",  {30'd0, bif.rvalid}, 32'd0);
      tick();
    end
    bif.mem_rvalid = 1'b1;
    bif.mem_err    = e;
    bif.mem_rdata  = rd;
    @(negedge clk);
    check("resp_mem_req_low", {31'd0, bif.mem_req}, 32'd0);
    tick();
    bif.mem_rvalid = 1'b0;
    bif.mem_err    = 1'b0;
    bif.mem_rdata  = 32'hA5A5_A5A5;
    if (rearm) bif.req[r] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    gexp_t g;
    rexp_t x;
    rst = 1'b0;
    bif.addr  = '0;
    bif.we    = '0;
    bif.be    = '0;
    bif.wdata = '0;
    reset_dut();

    // single read from requester 0
    run_txn(1'b0, 32'h0000_1000, 1'b0, 4'hF, 32'h0, 0, 1, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // contention from reset: order 0,1,0,1
    reset_dut();
    bif.addr[1]  = 32'h0000_00B0;
    bif.we[1]    = 1'b1;
    bif.be[1]    = 4'hF;
    bif.wdata[1] = 32'h1111_0000;
    bif.req[1]   = 1'b1;
    run_txn(1'b0, 32'h0000_00A0, 1'b0, 4'hF, 32'h0,         0, 0, 1'b0, 32'h0000_0A0A, 1'b1);
    run_txn(1'b1, 32'h0000_00B0, 1'b1, 4'hF, 32'h1111_0000, 0, 0, 1'b0, 32'h0,         1'b1);
    run_txn(1'b0, 32'h0000_00A4, 1'b0, 4'hF, 32'h0,         0, 0, 1'b0, 32'h0000_0A4A, 1'b1);
    run_txn(1'b1, 32'h0000_00B0, 1'b1, 4'hF, 32'h1111_0000, 0, 0, 1'b0, 32'h0,         1'b0);
    bif.req[0] = 1'b0;

    // stalled grant on a requester-1 write
    run_txn(1'b1, 32'h0000_3000, 1'b1, 4'b0011, 32'h1234_5678, 5, 0, 1'b0, 32'h0, 1'b0);

    // error response, then normal traffic
    run_txn(1'b0, 32'h0000_4000, 1'b0, 4'hF, 32'h0, 0, 0, 1'b1, 32'hBAD0_BAD0, 1'b0);
    run_txn(1'b1, 32'h0000_4004, 1'b0, 4'hF, 32'h0, 1, 2, 1'b0, 32'h600D_F00D, 1'b0);

    // reset while in RESP, then a stray mem_rvalid
    g.gvec = 2'b01; g.addr = 32'h0000_5000; g.we = 1'b0; g.be = 4'hF; g.wdata = 32'h0;
    gq.push_back(g);
    bif.req[0] = 1'b1; bif.addr[0] = 32'h0000_5000; bif.we[0] = 1'b0;
    bif.be[0] = 4'hF; bif.wdata[0] = 32'h0;
    bif.mem_gnt = 1'b1;
    tick();
    tick();
    bif.req[0] = 1'b0;
    bif.mem_gnt = 1'b0;
    reset_dut();
    bif.mem_rvalid = 1'b1;
    bif.mem_rdata  = 32'h0000_CAFE;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stray_rvalid", {30'd0, bif.rvalid}, 32'd0);
      check("stray_rdata",  bif.rdata, 32'd0);
      tick();
    end
    bif.mem_rvalid = 1'b0;
    run_txn(1'b0, 32'h0000_5004, 1'b0, 4'hF, 32'h0, 0, 0, 1'b0, 32'h1357_9BDF, 1'b0);

    // response watchdog
    g.gvec = 2'b01; g.addr = 32'h0000_6000; g.we = 1'b0; g.be = 4'hF; g.wdata = 32'h0;
    gq.push_back(g);
    bif.req[0] = 1'b1; bif.addr[0] = 32'h0000_6000; bif.we[0] = 1'b0;
    bif.be[0] = 4'hF; bif.wdata[0] = 32'h0;
    bif.mem_gnt = 1'b1;
    tick();
    tick();
    bif.req[0] = 1'b0;
    bif.mem_gnt = 1'b0;
`ifdef MEM_PORT_ARB_WATCHDOG_EN
    x.rvec = 2'b01; x.err = 1'b1; x.rdata = 32'h0;
    rq.push_back(x);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("wd_quiet", {30'd0, bif.rvalid}, 32'd0);
      tick();
    end
    @(negedge clk);
    check("wd_fire", {30'd0, bif.rvalid}, 32'd1);
    tick();
`else
    x.rvec = 2'b00; x.err = 1'b0; x.rdata = 32'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_wd_response", {30'd0, bif.rvalid}, {30'd0, x.rvec});
      tick();
    end
    reset_dut();
`endif
    run_txn(1'b1, 32'h0000_7000, 1'b0, 4'hF, 32'h0, 0, 0, 1'b0, 32'h2468_ACE0, 1'b0);

    repeat (2) tick();
    check("gq_drained", gq.size(), 32'd0);
    check("rq_drained", rq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single MMU memory port between the Ibex data interface (requester 0) and the Vicuna vector unit memory interface (requester 1). It sits between the cores and the `mmu` and presents one request/grant/response channel downstream. It keeps at most one transaction outstanding, uses round-robin priority on contention, and routes each response back to the requester that issued it.

## Interface
- `MEM_W`, 32, data bus width in bits; `MEM_W/8` byte enables
- `TIMEOUT_CYCLES`, 255, response watchdog limit in cycles (range 1..65535); used only with the watchdog macro
- `clk`  in  1  clock, all state on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req`  in  2  per-requester request; held with stable payload until the matching `gnt`
- `addr`  in  2x32  per-requester address
- `we`  in  2  per-requester write enable
- `be`  in  2x(MEM_W/8)  per-requester byte enables
- `wdata`  in  2xMEM_W  per-requester write data
- `gnt`  out  2  one-cycle grant pulse to the owner
- `rvalid`  out  2  one-cycle response valid to the owner
- `err`  out  1  error qualifier, valid with any `rvalid` bit
- `rdata`  out  MEM_W  response data, broadcast, valid with `rvalid`
- `mem_req`, `mem_addr[31:0]`, `mem_we`, `mem_be[MEM_W/8-1:0]`, `mem_wdata[MEM_W-1:0]`  out  downstream request to the MMU
- `mem_gnt`  in  1  MMU accepts `mem_req`
- `mem_rvalid`, `mem_err`, `mem_rdata[MEM_W-1:0]`  in  MMU response

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If no `req` bit is set, stay in IDLE.
  - If exactly one bit is set, that requester wins.
  - If both are set, the winner is `~last` (1-bit `last` holds the previous winner).
  - On a win, latch the winner into `owner`, register its addr/we/be/wdata, set `last <= owner`, and go to REQ.
- REQ:
  - `mem_req=1` and all `mem_*` outputs driven from the registered payload.
  - `gnt[owner] = mem_gnt` (combinational).
  - When `mem_gnt=1`, go to RESP; otherwise hold in REQ.
- RESP:
  - `rvalid[owner] = mem_rvalid`, `err = mem_err`, `rdata = mem_rdata` (combinational pass-through).
  - When `mem_rvalid=1`, go to IDLE.
- If `mem_rvalid` arrives in IDLE or REQ, it is discarded.
- Requests arriving while busy are not sampled; they wait until the next IDLE.
- A requester deasserting `req` before its `gnt` is a protocol violation and its behaviour is undefined.
- Reset mid-operation:
  - The FSM returns to IDLE and `last` to 1, so requester 0 wins the first tie.
  - The in-flight transaction is abandoned.
  - Any `mem_rvalid` arriving after reset in IDLE is discarded.

## Timing
- Reset values:
  - `gnt=0`, `rvalid=0`, `err=0`, `rdata=0`.
  - `mem_req=0`, `mem_addr=0`, `mem_we=0`, `mem_be=0`, `mem_wdata=0`.
  - Internally: state IDLE, `owner=0`, `last=1`.
- `rdata` and `err` are forced to 0 whenever no `rvalid` bit is high.
- Latency, with `req` sampled at edge N:
  - `mem_req` is high in cycle N+1.
  - The earliest `gnt` is in cycle N+1.
  - The earliest `rvalid` is in cycle N+2.
  - The next request is sampled at the end of cycle N+3.
  - Peak throughput is one transaction per 3 cycles.
- `mem_req` stays high with a stable payload until `mem_gnt`, and drops in the cycle after the grant.
- At most one `gnt` bit and one `rvalid` bit is set in any cycle.

## Configuration
- `MEM_PORT_ARB_WATCHDOG_EN` defined:
  - A 16-bit counter clears on entry to RESP and increments each RESP cycle without `mem_rvalid`.
  - When the counter equals `TIMEOUT_CYCLES - 1` with no `mem_rvalid`, the arbiter drives `rvalid[owner]=1`, `err=1`, `rdata=0` for that cycle and goes to IDLE.
  - The MMU must not issue a response for a timed-out transaction; any `mem_rvalid` outside RESP is discarded.
- Macro not defined:
  - The counter and the timeout logic are absent.
  - RESP waits indefinitely.

## Test plan
- Single read, requester 0: `addr=0x1000`, `mem_gnt` tied high, `mem_rvalid` with `rdata=0xDEADBEEF` two cycles later -> `gnt[0]` in N+1, `rvalid[0]=1`, `rdata=0xDEADBEEF`, `err=0`, `gnt[1]`/`rvalid[1]` never set.
- Contention: both `req` high from reset, back-to-back transactions -> grant order 0,1,0,1; `mem_addr` matches the owner's address every time.
- Stalled grant: `mem_gnt` low for 5 cycles on a requester-1 write (`be=4'b0011`, `wdata=0x12345678`) -> `mem_req` and payload stable for 6 cycles, a single `gnt[1]` pulse.
- Error response: `mem_err=1` with `mem_rvalid` -> `rvalid[owner]=1`, `err=1`, and the next transaction proceeds normally.
- Reset mid-RESP: assert `rst` low, release, then inject a stray `mem_rvalid` -> no `rvalid` output; all outputs at reset values; a new request from requester 0 completes.
- Watchdog (with `MEM_PORT_ARB_WATCHDOG_EN`, `TIMEOUT_CYCLES=8`): no `mem_rvalid` -> `rvalid[owner]=1`, `err=1`, `rdata=0` exactly 8 cycles after entering RESP; without the macro, no response ever appears.
